// File: rtl/pci_pkg.sv
// Shared constants, status-bit mapping and MSI state type for the PCI config block.
package pci_pkg;

    localparam logic [5:0] CFG_ID          = 6'h00;
    localparam logic [5:0] CFG_CMD_STAT    = 6'h01;
    localparam logic [5:0] CFG_CLASS       = 6'h02;
    localparam logic [5:0] CFG_MISC        = 6'h03;
    localparam logic [5:0] CFG_BAR0        = 6'h04;
    localparam logic [5:0] CFG_CAP_PTR     = 6'h0d;
    localparam logic [5:0] CFG_INTR        = 6'h0f;
    localparam logic [5:0] CFG_MSI_CAP     = 6'h10;
    localparam logic [5:0] CFG_MSI_ADDR_LO = 6'h11;
    localparam logic [5:0] CFG_MSI_ADDR_HI = 6'h12;
    localparam logic [5:0] CFG_MSI_DATA    = 6'h13;
    localparam logic [5:0] CFG_MSI_MASK    = 6'h14;
    localparam logic [5:0] CFG_MSI_PENDING = 6'h15;

    localparam logic [31:0] CFG_CLASS_REV = 32'hff00_0000;
    localparam logic [7:0]  MSI_CAP_PTR   = 8'h40;
    localparam logic [7:0]  MSI_CAP_ID    = 8'h05;
    localparam logic [15:0] CMD_WMASK     = 16'h0546;

    localparam int STAT_INTR     = 19;
    localparam int STAT_CAP_LIST = 20;
    localparam int STAT_MDPE     = 24;
    localparam int STAT_STA      = 27;
    localparam int STAT_RTA      = 28;
    localparam int STAT_RMA      = 29;
    localparam int STAT_SSE      = 30;
    localparam int STAT_DPE      = 31;

    typedef enum logic {MSI_IDLE, MSI_SEND} msi_state_t;

    // status_evt[5:0] occupies these dword bits, lowest event first
    function automatic logic [31:0] evt_to_dword(input logic [5:0] e);
        logic [31:0] d;
        d = '0;
        d[STAT_MDPE] = e[0];
        d[STAT_STA]  = e[1];
        d[STAT_RTA]  = e[2];
        d[STAT_RMA]  = e[3];
        d[STAT_SSE]  = e[4];
        d[STAT_DPE]  = e[5];
        return d;
    endfunction

    function automatic logic [5:0] dword_to_evt(input logic [31:0] d);
        return {d[STAT_DPE], d[STAT_SSE], d[STAT_RMA], d[STAT_RTA], d[STAT_STA], d[STAT_MDPE]};
    endfunction

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pci_msi_gen.sv
// MSI pending bits, lowest-index arbitration and the valid/ack message handshake.
module pci_msi_gen
    import pci_pkg::*;
#(
    parameter int MSI_VEC_LOG2 = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         msi_enable,
    input  logic                         bus_master_en,
    input  logic [2:0]                   mme,
    input  logic [63:0]                  addr_reg,
    input  logic [15:0]                  data_reg,
    input  logic [2**MSI_VEC_LOG2-1:0]   vec_mask,
    input  logic [2**MSI_VEC_LOG2-1:0]   msi_req,
    input  logic                         msi_ack,
    output logic                         msi_valid,
    output logic [63:0]                  msi_addr,
    output logic [15:0]                  msi_data,
    output logic [2**MSI_VEC_LOG2-1:0]   pending
);

    localparam int NV = 2**MSI_VEC_LOG2;

    msi_state_t   state;
    logic [4:0]   cur_vec;
    logic [NV-1:0] eligible;
    logic [NV-1:0] ack_clr;
    logic [4:0]   pick;
    logic [15:0]  low_mask;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        eligible = pending & ~vec_mask;
        pick     = lowest_set(32'(eligible));
        low_mask = (16'd1 << mme) - 16'd1;
        ack_clr  = '0;
        if (state == MSI_SEND && msi_ack) ack_clr = NV'(1) << cur_vec;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= MSI_IDLE;
            cur_vec   <= '0;
            pending   <= '0;
            msi_valid <= 1'b0;
            msi_addr  <= '0;
            msi_data  <= '0;
        end else begin
            // a request landing on the ack edge re-arms the vector being retired
            if (!msi_enable) pending <= '0;
            else             pending <= (pending & ~ack_clr) | msi_req;

            case (state)
                MSI_IDLE: begin
                    if (msi_enable && bus_master_en && |eligible) begin
                        state     <= MSI_SEND;
                        cur_vec   <= pick;
                        msi_valid <= 1'b1;
                        msi_addr  <= addr_reg;
                        msi_data  <= (data_reg & ~low_mask) | (16'(pick) & low_mask);
                    end
                end
                MSI_SEND: begin
                    if (msi_ack) begin
                        state     <= MSI_IDLE;
                        msi_valid <= 1'b0;
                    end
                end
                default: state <= MSI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pci_cfg_gen2.sv
// PCI type-0 config space with memory BARs and a 64-bit MSI capability at 0x40.
// Define PCI_MSI_PVM_EN to add per-vector Mask/Pending registers.
module pci_cfg_gen2
    import pci_pkg::*;
#(
    parameter logic [15:0] PCI_VENDOR_ID = 16'h1234,
    parameter logic [15:0] PCI_DEVICE_ID = 16'h11e8,
    parameter int          NUM_BARS      = 1,
    parameter int          BAR_SIZE_LOG2 = 12,
    parameter int          MSI_VEC_LOG2  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_enable,
    input  logic                        cfg_iswrite,
    input  logic [5:0]                  cfg_offset,
    input  logic [31:0]                 cfg_write_val,
    input  logic [3:0]                  cfg_be,
    output logic [31:0]                 cfg_read_val,
    output logic                        cfg_done,
    output logic                        cfg_w_err,
    input  logic [5:0]                  status_evt,
    input  logic                        intr_status,
    output logic [NUM_BARS*32-1:0]      bar_base,
    output logic                        mem_space_en,
    output logic                        bus_master_en,
    output logic                        intx_assert,
    input  logic [2**MSI_VEC_LOG2-1:0]  msi_req,
    output logic                        msi_valid,
    output logic [63:0]                 msi_addr,
    output logic [15:0]                 msi_data,
    input  logic                        msi_ack
);

    localparam int          NV       = 2**MSI_VEC_LOG2;
    localparam logic [31:0] BAR_MASK = ~((32'd1 << BAR_SIZE_LOG2) - 32'd1);
`ifdef PCI_MSI_PVM_EN
    localparam logic PVM_CAP = 1'b1;
`else
    localparam logic PVM_CAP = 1'b0;
`endif

    logic [15:0]   cmd_q;
    logic [5:0]    stat_evt_q;
    logic [7:0]    cacheline_q, latency_q, int_line_q;
    logic [31:0]   bar_q [NUM_BARS];
    logic          msi_en_q;
    logic [2:0]    mme_q;
    logic [31:0]   msi_addr_lo_q, msi_addr_hi_q;
    logic [15:0]   msi_data_q;
    logic [NV-1:0] vec_mask;
    logic [NV-1:0] pending;

    logic          accept, wr, bar_hit, wr_err;
    logic [31:0]   wbe, rdata;
    logic [15:0]   cmd_next, msg_ctrl;
    logic [5:0]    stat_clr;
    logic [2:0]    mme_wr;

    assign mem_space_en  = cmd_q[1];
    assign bus_master_en = cmd_q[2];
    assign msg_ctrl      = {7'b0, PVM_CAP, 1'b1, mme_q, 3'(MSI_VEC_LOG2), msi_en_q};

    always_comb begin
        accept   = cfg_enable & ~cfg_done;
        wr       = accept & cfg_iswrite;
        wbe      = {{8{cfg_be[3]}}, {8{cfg_be[2]}}, {8{cfg_be[1]}}, {8{cfg_be[0]}}};
        bar_hit  = 1'b0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (cfg_offset == CFG_BAR0 + 6'(i)) bar_hit = 1'b1;
        end
        // partial writes to registers that must change atomically are refused
        wr_err   = wr && (cfg_be != 4'hf) &&
                   (bar_hit || cfg_offset == CFG_MSI_ADDR_LO || cfg_offset == CFG_MSI_ADDR_HI);
        cmd_next = (cmd_q & ~(CMD_WMASK & wbe[15:0])) | (cfg_write_val[15:0] & CMD_WMASK & wbe[15:0]);
        mme_wr   = (cfg_write_val[22:20] > 3'(MSI_VEC_LOG2)) ? 3'(MSI_VEC_LOG2) : cfg_write_val[22:20];
        stat_clr = (wr && cfg_offset == CFG_CMD_STAT && cfg_be[3]) ? dword_to_evt(cfg_write_val) : '0;
    end

    always_comb begin
        rdata = '0;
        case (cfg_offset)
            CFG_ID:          rdata = {PCI_DEVICE_ID, PCI_VENDOR_ID};
            CFG_CMD_STAT:    rdata = evt_to_dword(stat_evt_q) | (32'(intr_status) << STAT_INTR) |
                                     (32'd1 << STAT_CAP_LIST) | {16'h0, cmd_q};
            CFG_CLASS:       rdata = CFG_CLASS_REV;
            CFG_MISC:        rdata = {16'h0, latency_q, cacheline_q};
            CFG_CAP_PTR:     rdata = {24'h0, MSI_CAP_PTR};
            CFG_INTR:        rdata = {16'h0, 8'h01, int_line_q};
            CFG_MSI_CAP:     rdata = {msg_ctrl, 8'h00, MSI_CAP_ID};
            CFG_MSI_ADDR_LO: rdata = msi_addr_lo_q;
            CFG_MSI_ADDR_HI: rdata = msi_addr_hi_q;
            CFG_MSI_DATA:    rdata = {16'h0, msi_data_q};
`ifdef PCI_MSI_PVM_EN
            CFG_MSI_MASK:    rdata = 32'(vec_mask);
            CFG_MSI_PENDING: rdata = 32'(pending);
`endif
            default:         rdata = '0;
        endcase
        for (int i = 0; i < NUM_BARS; i++) begin
            if (cfg_offset == CFG_BAR0 + 6'(i)) rdata = bar_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q         <= '0;
            stat_evt_q    <= '0;
            cacheline_q   <= '0;
            latency_q     <= '0;
            int_line_q    <= '0;
            msi_en_q      <= 1'b0;
            mme_q         <= '0;
            msi_addr_lo_q <= '0;
            msi_addr_hi_q <= '0;
            msi_data_q    <= '0;
            cfg_done      <= 1'b0;
            cfg_w_err     <= 1'b0;
            cfg_read_val  <= '0;
            intx_assert   <= 1'b0;
            // NOTE: the BAR array is a handful of flops, not a RAM, so it is reset explicitly.
            for (int i = 0; i < NUM_BARS; i++) bar_q[i] <= '0;
        end else begin
            stat_evt_q  <= (stat_evt_q & ~stat_clr) | status_evt;
            intx_assert <= intr_status & ~cmd_q[10] & ~msi_en_q;

            if (accept) begin
                cfg_done     <= 1'b1;
                cfg_read_val <= rdata;
                cfg_w_err    <= wr_err;
            end else if (!cfg_enable) begin
                cfg_done  <= 1'b0;
                cfg_w_err <= 1'b0;
            end

            if (wr && !wr_err) begin
                case (cfg_offset)
                    CFG_CMD_STAT: cmd_q <= cmd_next;
                    CFG_MISC: begin
                        if (cfg_be[0]) cacheline_q <= cfg_write_val[7:0];
                        if (cfg_be[1]) latency_q   <= cfg_write_val[15:8];
                    end
                    CFG_INTR: if (cfg_be[0]) int_line_q <= cfg_write_val[7:0];
                    CFG_MSI_CAP: begin
                        if (cfg_be[2]) begin
                            msi_en_q <= cfg_write_val[16];
                            mme_q    <= mme_wr;
                        end
                    end
                    CFG_MSI_ADDR_LO: msi_addr_lo_q <= {cfg_write_val[31:2], 2'b00};
                    CFG_MSI_ADDR_HI: msi_addr_hi_q <= cfg_write_val;
                    CFG_MSI_DATA: begin
                        if (cfg_be[0]) msi_data_q[7:0]  <= cfg_write_val[7:0];
                        if (cfg_be[1]) msi_data_q[15:8] <= cfg_write_val[15:8];
                    end
                    default: ;
                endcase
                for (int i = 0; i < NUM_BARS; i++) begin
                    if (cfg_offset == CFG_BAR0 + 6'(i)) bar_q[i] <= cfg_write_val & BAR_MASK;
                end
            end
        end
    end

`ifdef PCI_MSI_PVM_EN
    logic [NV-1:0] mask_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '0;
        end else if (wr && cfg_offset == CFG_MSI_MASK) begin
            mask_q <= NV'((32'(mask_q) & ~wbe) | (cfg_write_val & wbe));
        end
    end
    assign vec_mask = mask_q;
`else
    assign vec_mask = '0;
`endif

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar_out
        assign bar_base[g*32 +: 32] = bar_q[g];
    end

    pci_msi_gen #(.MSI_VEC_LOG2(MSI_VEC_LOG2)) u_msi (
        .clk          (clk),
        .rst          (rst),
        .msi_enable   (msi_en_q),
        .bus_master_en(cmd_q[2]),
        .mme          (mme_q),
        .addr_reg     ({msi_addr_hi_q, msi_addr_lo_q}),
        .data_reg     (msi_data_q),
        .vec_mask     (vec_mask),
        .msi_req      (msi_req),
        .msi_ack      (msi_ack),
        .msi_valid    (msi_valid),
        .msi_addr     (msi_addr),
        .msi_data     (msi_data),
        .pending      (pending)
    );

endmodule

// File: doc/pci_cfg_gen2.md
PCI_CFG_GEN2 -- requirements
Module: pci_cfg_gen2

Interface
REQ-001 SHALL take parameter PCI_VENDOR_ID, default 16'h1234: Vendor ID.
REQ-002 SHALL take parameter PCI_DEVICE_ID, default 16'h11e8: Device ID.
REQ-003 SHALL take parameter NUM_BARS, default 1, range 1..6: number of implemented 32-bit memory BARs.
REQ-004 SHALL take parameter BAR_SIZE_LOG2, default 12, range 4..31: log2 of the size of every implemented BAR.
REQ-005 SHALL take parameter MSI_VEC_LOG2, default 0, range 0..5: log2 of the MSI Multiple Message Capable field.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-008 SHALL have ports cfg_enable (in, 1), cfg_iswrite (in, 1), cfg_offset (in, 6, dword index), cfg_write_val (in, 32), cfg_be (in, 4): config access request.
REQ-009 SHALL have ports cfg_read_val (out, 32), cfg_done (out, 1), cfg_w_err (out, 1): access response.
REQ-010 SHALL have port status_evt, input, 6: one-cycle error pulses mapped to status bits 24, 27, 28, 29, 30, 31, in that order.
REQ-011 SHALL have port intr_status, input, 1: level-sensitive device interrupt.
REQ-012 SHALL have ports bar_base (out, NUM_BARS*32), mem_space_en (out, 1), bus_master_en (out, 1), intx_assert (out, 1).
REQ-013 SHALL have port msi_req, input, 2**MSI_VEC_LOG2: per-vector one-cycle request pulses.
REQ-014 SHALL have ports msi_valid (out, 1), msi_addr (out, 64), msi_data (out, 16), msi_ack (in, 1): MSI write handshake.

Function
REQ-015 SHALL accept an access when cfg_enable=1 and cfg_done=0, and SHALL assert cfg_done the next cycle, holding it until cfg_enable=0; it SHALL execute each access exactly once.
REQ-016 SHALL return the header at dwords 0x00-0x0F, with the capabilities pointer at 0x40 and the MSI capability (64-bit) at dword 0x10; undefined offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-017 SHALL latch each status_evt pulse into its status bit; a write of 1 with cfg_be[3] SHALL clear that bit; an event in the same cycle as a clear SHALL leave the bit set.
REQ-018 SHALL hardwire BAR bits [BAR_SIZE_LOG2-1:0] to 0 (bit 3 prefetchable=0, type=00); writing FFFFFFFF SHALL read back ~(2**BAR_SIZE_LOG2-1).
REQ-019 SHALL read unimplemented BARs (index >= NUM_BARS) as 0.
REQ-020 SHALL, on a write with cfg_be != 4'b1111 to any implemented BAR or to the MSI address dwords, ignore the write and assert cfg_w_err together with cfg_done.
REQ-021 SHALL clamp a write to Multiple Message Enable that exceeds MSI_VEC_LOG2 to MSI_VEC_LOG2.
REQ-022 SHALL set a pending bit per msi_req pulse while msi_enable=1, and SHALL clear all pending bits while msi_enable=0.
REQ-023 SHALL implement MSI states IDLE and SEND:
- IDLE to SEND when a pending bit is set, bus_master_en=1 and the vector is unmasked; the lowest-index such vector is chosen.
- SEND to IDLE on msi_valid & msi_ack.
REQ-024 SHALL, in SEND, hold msi_valid=1 with msi_addr and msi_data stable; msi_data SHALL equal the data register with its low MME bits replaced by vector & (2**MME-1).
REQ-025 SHALL clear the sent pending bit on acknowledge unless a new msi_req for that vector arrives in the same cycle, in which case it SHALL stay set.
REQ-026 SHALL complete a message in flight if msi_enable is cleared during SEND.
REQ-027 SHALL drive intx_assert = intr_status & ~intx_disable & ~msi_enable, and status bit 19 = intr_status.

Reset
REQ-028 SHALL, on rst=0 at a clock edge, reset as follows:
- command, status, BARs, cacheline, latency, interrupt line, all MSI registers and pending bits: 0;
- MSI state: IDLE;
- outputs cfg_done, cfg_w_err, msi_valid, cfg_read_val, intx_assert: 0;
- an access or message in progress is abandoned.

Configuration
REQ-029 SHALL, with PCI_MSI_PVM_EN defined, set Per-Vector Mask Capable (bit 24), implement Mask at dword 0x14 (RW) and Pending at dword 0x15 (RO), and hold masked vectors pending without sending them.
REQ-030 SHALL, without PCI_MSI_PVM_EN, read bit 24 and dwords 0x14-0x15 as 0, ignore writes to them, and treat every vector as unmasked.

Structure
REQ-031 SHALL take its config dword offset constants (including CFG_MSI_MASK and CFG_MSI_PENDING), status bit indices and the MSI state enum typedef from pci_pkg.
REQ-032 SHALL place the pending, arbitration and handshake logic in sub-module pci_msi_gen.

Verification
REQ-033 SHALL verify BAR sizing: NUM_BARS=2, BAR_SIZE_LOG2=12; write FFFFFFFF to BAR1 -> reads FFFFF000; BAR2 reads 00000000.
REQ-034 SHALL verify W1C: pulse status_evt[3] -> bit 29 set; write 0x20000000 with be=1000 in the same cycle as a second pulse -> bit stays set; a later write -> cleared.
REQ-035 SHALL verify MSI: MSI_VEC_LOG2=2, MME=2, data=0x4000, bus master on; pulse msi_req[3] and msi_req[1] together -> msi_data 0x4001 then 0x4003, each held until ack.
REQ-036 SHALL verify clamping and errors: write MME=7 -> reads 2; BAR0 write with be=0011 -> cfg_w_err=1, BAR0 unchanged.
REQ-037 SHALL verify reset mid-SEND: rst=0 for one cycle while msi_valid=1 -> msi_valid=0 next cycle; all pending cleared; header re-read shows reset values.
